seven_segment_seconds: RTL and testbench

- Top-level user block for the tile I/O frame.
- Drives a single common-cathode seven-segment digit that counts 0..9 and wraps.
- The digit advances at a programmable tick rate: default one tick per second at a 10 MHz clock, or a faster rate selected from ui_in for simulation and bring-up.
- Bidirectional pins are unused and held as inputs.

---
 rtl/seven_segment_seconds_if.sv | 20 ++
 rtl/seven_segment_seconds.sv | 74 +++++++
 tb/tb_seven_segment_seconds.sv | 120 ++++++++++++
 3 files changed

// File: rtl/seven_segment_seconds_if.sv
// Pin bundle of the seven-segment seconds tile: enable, rate select, and the
// three 8-bit output/bidirectional groups of the I/O frame.
interface seven_segment_seconds_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/seven_segment_seconds.sv
// Single seven-segment digit counting 0..9 at a programmable tick rate.
// Optional macro SEG_DP_BLINK_EN: decimal point toggles on every digit step.
module seven_segment_seconds #(
  parameter int CLK_TICKS = 10_000_000
) (
  input logic                    clk,
  input logic                    rst_n,  // active-high despite the name
  seven_segment_seconds_if.slave bus
);

  localparam logic [23:0] TICKS = 24'(CLK_TICKS);

  logic [23:0] cnt;
  logic [23:0] limit;
  logic [3:0]  dig;
  logic        step;
  logic [6:0]  seg;
  logic        dp;
  logic        unused_uio;

  always_comb begin
    // NOTE: default first so every path assigns limit and no latch is inferred.
    limit = TICKS;
    if (bus.ui_in != 8'd0) limit = {6'd0, bus.ui_in, 10'd0};
  end

  // >= rather than == so a rate cut below the current count rolls over at once.
  assign step = bus.ena && (cnt >= limit - 24'd1);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      // NOTE: non-blocking assignments for all clocked state.
      cnt <= 24'd0;
      dig <= 4'd0;
    end else if (step) begin
      cnt <= 24'd0;
      dig <= (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
    end else if (bus.ena) begin
      cnt <= cnt + 24'd1;
    end
  end

`ifdef SEG_DP_BLINK_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)     dp <= 1'b0;
    else if (step) dp <= ~dp;
  end
`else
  assign dp = 1'b0;
`endif

  // Segment order {g,f,e,d,c,b,a}; illegal digits blank the display.
  always_comb begin
    case (dig)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

  assign bus.uo_out  = {dp, seg};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;
  assign unused_uio  = ^bus.uio_in;

endmodule

// File: tb/tb_seven_segment_seconds.sv
// Directed, table-driven bench for seven_segment_seconds: rate select, wrap,
// enable freeze, mid-count rate change, asynchronous reset.
module tb_seven_segment_seconds;

`ifdef SEG_DP_BLINK_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  typedef struct {
    logic       ena;
    logic [7:0] ui;
    int         n;      // clock edges to apply before comparing
    logic [6:0] seg;
    logic       dp;     // expected dp when blinking is built in
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];

  seven_segment_seconds_if bus ();

  seven_segment_seconds #(.CLK_TICKS(10_000_000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] expect_out(input logic [6:0] seg, input logic dp);
    return {DP_EN & dp, seg};
  endfunction

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Cumulative schedule from reset release with L = 1024 unless noted.
    vecs.push_back('{1'b1, 8'd1, 1023, 7'h3F, 1'b0, "hold_1023"});
    vecs.push_back('{1'b1, 8'd1,    1, 7'h06, 1'b1, "step_1024"});
    vecs.push_back('{1'b1, 8'd1, 1023, 7'h06, 1'b1, "hold_2047"});
    vecs.push_back('{1'b1, 8'd1,    1, 7'h5B, 1'b0, "step_2048"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h4F, 1'b1, "dig3"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h66, 1'b0, "dig4"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h6D, 1'b1, "dig5"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h7D, 1'b0, "dig6"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h07, 1'b1, "dig7"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h7F, 1'b0, "dig8"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h6F, 1'b1, "dig9"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h3F, 1'b0, "wrap0"});
    // Freeze mid-period: 500 counted, 5000 frozen, 523 + 1 to finish.
    vecs.push_back('{1'b1, 8'd1,  500, 7'h3F, 1'b0, "pre_freeze"});
    vecs.push_back('{1'b0, 8'd1, 5000, 7'h3F, 1'b0, "frozen"});
    vecs.push_back('{1'b1, 8'd1,  523, 7'h3F, 1'b0, "resume_hold"});
    vecs.push_back('{1'b1, 8'd1,    1, 7'h06, 1'b1, "resume_step"});
    // L = 4096 for 3000 cycles, then drop to 1024: rolls over on the next edge.
    vecs.push_back('{1'b1, 8'd4, 3000, 7'h06, 1'b1, "slow_3000"});
    vecs.push_back('{1'b1, 8'd1,    1, 7'h5B, 1'b0, "rate_cut_step"});
    vecs.push_back('{1'b1, 8'd1, 1023, 7'h5B, 1'b0, "after_cut_hold"});
    vecs.push_back('{1'b1, 8'd1,    1, 7'h4F, 1'b1, "after_cut_step"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h66, 1'b0, "to_dig4"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h6D, 1'b1, "to_dig5"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h7D, 1'b0, "to_dig6"});
    vecs.push_back('{1'b1, 8'd1, 1024, 7'h07, 1'b1, "to_dig7"});
    vecs.push_back('{1'b1, 8'd1,  500, 7'h07, 1'b1, "mid_dig7"});

    bus.ena    = 1'b1;
    bus.ui_in  = 8'd0;
    bus.uio_in = 8'hA5;
    rst_n      = 1'b1;
    run(10);
    check("reset_uo_out", bus.uo_out, 8'h3F);
    check("reset_uio_out", bus.uio_out, 8'h00);
    check("reset_uio_oe", bus.uio_oe, 8'h00);

    bus.ui_in = 8'd1;
    rst_n     = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.ena   = vecs[i].ena;
      bus.ui_in = vecs[i].ui;
      run(vecs[i].n);
      check(vecs[i].name, bus.uo_out, expect_out(vecs[i].seg, vecs[i].dp));
    end
    check("run_uio_out", bus.uio_out, 8'h00);
    check("run_uio_oe", bus.uio_oe, 8'h00);

    // Asynchronous reset between edges: output must clear before any posedge.
    #2 rst_n = 1'b1;
    #1 check("async_reset", bus.uo_out, 8'h3F);
    run(3);
    check("async_reset_hold", bus.uo_out, 8'h3F);
    rst_n = 1'b0;
    check("release", bus.uo_out, 8'h3F);
    run(1023);
    check("post_reset_hold", bus.uo_out, expect_out(7'h3F, 1'b0));
    run(1);
    check("post_reset_step1", bus.uo_out, expect_out(7'h06, 1'b1));
    run(1024);
    check("post_reset_step2", bus.uo_out, expect_out(7'h5B, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
